// File: rtl/cla_seq_ctrl.sv
// Chunk-serial wide adder sequencer: drives one narrow CLA slice per chunk, holding each
// chunk SETTLE cycles and rippling the chunk carry through a register.
module cla_seq_ctrl #(
   parameter int CHUNK_W = 3,
   parameter int NCHUNK  = 4,
   parameter int SETTLE  = 2,
   localparam int W      = CHUNK_W * NCHUNK
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       in_a,
   input  logic [W-1:0]       in_b,
   input  logic               in_cin,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W-1:0]       out_sum,
   output logic               out_cout,
   output logic [CHUNK_W-1:0] add_a,
   output logic [CHUNK_W-1:0] add_b,
   output logic               add_c0,
   input  logic [CHUNK_W-1:0] add_s,
   input  logic               add_c3
);

   // state | meaning
   // IDLE  | waiting for a request, in_ready high
   // RUN   | presenting chunk idx to the slice, cnt counts settle cycles
   // DONE  | result held on out_* until out_ready

   generate
      if (SETTLE < 1) begin : g_bad_settle
         $error("cla_seq_ctrl: SETTLE must be >= 1");
      end
   endgenerate

   localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      int lsb;
      lsb     = CHUNK_W * int'(idx_q);
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      add_a   = '0;
      add_b   = '0;
      add_c0  = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               carry_d = in_cin;
               idx_d   = '0;
               cnt_d   = '0;
               sum_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // slice inputs come only from registers so the adder sees a stable chunk
            add_a  = a_q[lsb +: CHUNK_W];
            add_b  = b_q[lsb +: CHUNK_W];
            add_c0 = carry_q;
            if (cnt_q != CNT_LAST) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               sum_d[lsb +: CHUNK_W] = add_s;
               carry_d = add_c3;
               cnt_d   = '0;
               if (idx_q == IDX_LAST) begin
                  cout_d  = add_c3;
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed and random bench for cla_seq_ctrl with a delayed behavioural 3-bit CLA slice.
module tb_cla_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] in_a = '0;
   logic [11:0] in_b = '0;
   logic        in_cin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [11:0] out_sum;
   logic        out_cout;
   logic [2:0]  add_a, add_b, add_s;
   logic        add_c0, add_c3;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   // slice settles well inside one SETTLE window
   assign #7 {add_c3, add_s} = {1'b0, add_a} + {1'b0, add_b} + {3'b000, add_c0};

   cla_seq_ctrl #(.CHUNK_W(3), .NCHUNK(4), .SETTLE(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout),
      .add_a(add_a), .add_b(add_b), .add_c0(add_c0),
      .add_s(add_s), .add_c3(add_c3)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic fail_timeout(input string name);
      total++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic run_add(input logic [11:0] a, input logic [11:0] b, input logic cin,
                          output logic [11:0] s, output logic co, output int lat,
                          output logic [7:0] c0tr);
      int guard;
      c0tr = '0; lat = 0; s = '0; co = 1'b0;
      @(negedge clk);
      in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         in_valid = 1'b0;
         fail_timeout("accept");
         return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      c0tr[0] = add_c0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
         if (!out_valid && lat < 8) c0tr[lat] = add_c0;
      end
      if (!out_valid) begin
         fail_timeout("out_valid");
         return;
      end
      s  = out_sum;
      co = out_cout;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   typedef struct {
      logic [11:0] a;
      logic [11:0] b;
      logic        cin;
      logic [11:0] sum;
      logic        cout;
      logic [7:0]  c0tr;   // add_c0 sampled each RUN cycle, bit k = cycle k
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [11:0] s;
      logic        co;
      int          lat;
      logic [7:0]  c0tr;
      logic [12:0] expv;
      logic [11:0] bb_a[3], bb_b[3], bb_s[3];
      logic        bb_c[3], bb_co[3];
      int          acc[3];
      int          n_in, n_out, guard;

      vecs[0] = '{12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 8'hFC};
      vecs[1] = '{12'h555, 12'h2AA, 1'b1, 12'h800, 1'b0, 8'hFF};
      vecs[2] = '{12'h555, 12'hAAA, 1'b1, 12'h000, 1'b1, 8'hFF};
      vecs[3] = '{12'h000, 12'h000, 1'b0, 12'h000, 1'b0, 8'h00};
      vecs[4] = '{12'h123, 12'h456, 1'b0, 12'h579, 1'b0, 8'h0C};
      vecs[5] = '{12'h001, 12'h002, 1'b0, 12'h003, 1'b0, 8'h00};
      vecs[6] = '{12'h800, 12'h800, 1'b0, 12'h000, 1'b1, 8'h00};
      vecs[7] = '{12'h7FF, 12'h000, 1'b1, 12'h800, 1'b0, 8'hFF};
      vecs[8] = '{12'hABC, 12'hDEF, 1'b1, 12'h8AC, 1'b1, 8'hFF};

      // reset state
      #12;
      check("rst_flags", {in_ready, out_valid, out_cout}, 3'b100);
      check("rst_sum", out_sum, 12'h000);
      check("rst_add", {add_a, add_b, add_c0}, 7'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_add(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, lat, c0tr);
         check($sformatf("vec%0d_sum", i), s, vecs[i].sum);
         check($sformatf("vec%0d_cout", i), co, vecs[i].cout);
         check($sformatf("vec%0d_latency", i), lat, 8);
         check($sformatf("vec%0d_c0trace", i), c0tr, vecs[i].c0tr);
      end

      // reset in the 4th RUN cycle; out_cout is still 1 from the previous add
      @(negedge clk);
      in_a = 12'h123; in_b = 12'h456; in_cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("midrun_busy", {in_ready, out_cout}, 2'b01);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_flags", {in_ready, out_valid, out_cout}, 3'b100);
      check("midrst_sum", out_sum, 12'h000);
      check("midrst_add", {add_a, add_b, add_c0}, 7'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_add(12'h001, 12'h002, 1'b0, s, co, lat, c0tr);
      check("post_rst_result", {co, s}, 13'h0003);
      check("post_rst_latency", lat, 8);

      // in_valid ignored during RUN and DONE; result held while out_ready low
      @(negedge clk);
      in_a = 12'h123; in_b = 12'h456; in_cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      in_a = 12'hFFF; in_b = 12'hFFF; in_cin = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!out_valid) fail_timeout("hold_valid");
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_a = 12'h0F0 + 12'(k);
         check($sformatf("hold%0d", k), {out_valid, in_ready, out_cout, out_sum}, {3'b100, 12'h579});
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("release", {out_valid, in_ready, out_cout, out_sum}, {3'b010, 12'h579});

      // back-to-back requests with out_ready tied high
      bb_a[0] = 12'h001; bb_b[0] = 12'h001; bb_c[0] = 1'b0; bb_s[0] = 12'h002; bb_co[0] = 1'b0;
      bb_a[1] = 12'hFFF; bb_b[1] = 12'hFFF; bb_c[1] = 1'b1; bb_s[1] = 12'hFFF; bb_co[1] = 1'b1;
      bb_a[2] = 12'h100; bb_b[2] = 12'h200; bb_c[2] = 1'b0; bb_s[2] = 12'h300; bb_co[2] = 1'b0;
      acc[0] = 0; acc[1] = 0; acc[2] = 0;
      n_in = 0; n_out = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge clk);
         if (out_valid && n_out < 3) begin
            check($sformatf("b2b_res%0d", n_out), {out_cout, out_sum}, {bb_co[n_out], bb_s[n_out]});
            n_out++;
         end
         if (n_in < 3) begin
            in_valid = 1'b1;
            in_a = bb_a[n_in]; in_b = bb_b[n_in]; in_cin = bb_c[n_in];
            if (in_ready) begin
               acc[n_in] = cyc;
               n_in++;
            end
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("b2b_count", n_out, 3);
      check("b2b_gap01", acc[1] - acc[0], 10);
      check("b2b_gap12", acc[2] - acc[1], 10);

      // random operands against a+b+cin
      for (int r = 0; r < 1000; r++) begin
         logic [11:0] ra, rb;
         logic        rc;
         ra = 12'($urandom_range(0, 4095));
         rb = 12'($urandom_range(0, 4095));
         rc = 1'($urandom_range(0, 1));
         expv = {1'b0, ra} + {1'b0, rb} + {12'd0, rc};
         run_add(ra, rb, rc, s, co, lat, c0tr);
         check($sformatf("rand%0d_%0h_%0h_%0h", r, ra, rb, rc), {co, s}, expv);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
